// File: rtl/control_multiciclo.sv
// control_multiciclo: multi-cycle RV32I control FSM sequencing fetch/decode/execute/writeback
// Rev 1.0 - initial release
`default_nettype none

module control_multiciclo (
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] instr,
    input  logic        alu_z,
    input  logic        mem_ready,
    output logic [3:0]  alu_sel,
    output logic [1:0]  sel_a,
    output logic [1:0]  sel_b,
    output logic [2:0]  imm_sel,
    output logic [1:0]  res_sel,
    output logic        pc_src,
    output logic        addr_sel,
    output logic        mem_valid,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        illegal
);

    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT  = 4'b0100;
    localparam logic [3:0] c_ALU_SLTU = 4'b0110;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_LUI       = 4'd4,
        S_AUIPC     = 4'd5,
        S_ALU_WB    = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_RD    = 4'd8,
        S_MEM_WB    = 4'd9,
        S_MEM_WR    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JALR_ADDR = 4'd12,
        S_LINK      = 4'd13,
        S_ILLEGAL   = 4'd14
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_illegal;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [2:0]  w_imm_sel;
    logic        w_taken;
    logic        w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

    // Branch compare yields Y==0 for "equal" / "not less"; invert per funct3
    assign w_taken = alu_z ^ (w_funct3[0] ^ w_funct3[2]);

    always_comb begin
        w_imm_sel = 3'd0;
        case (w_opcode)
            c_OP_STORE:          w_imm_sel = 3'd1;
            c_OP_BRANCH:         w_imm_sel = 3'd2;
            c_OP_LUI, c_OP_AUIPC: w_imm_sel = 3'd3;
            c_OP_JAL:            w_imm_sel = 3'd4;
            default:             w_imm_sel = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_ILLEGAL);
        end
    end

    always_comb begin
        w_next    = r_state;
        alu_sel   = c_ALU_ADD;
        sel_a     = 2'd0;
        sel_b     = 2'd0;
        imm_sel   = w_imm_sel;
        res_sel   = 2'd0;
        pc_src    = 1'b0;
        addr_sel  = 1'b0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_valid = 1'b1;
                sel_b     = 2'd2;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                sel_a = 2'd2;
                sel_b = 2'd1;
                case (w_opcode)
                    c_OP_REG:               w_next = S_EXEC_R;
                    c_OP_IMM:               w_next = S_EXEC_I;
                    c_OP_LOAD, c_OP_STORE:  w_next = S_MEM_ADDR;
                    c_OP_BRANCH:            w_next = S_BRANCH;
                    c_OP_JAL:               w_next = S_LINK;
                    c_OP_JALR:              w_next = S_JALR_ADDR;
                    c_OP_LUI:               w_next = S_LUI;
                    c_OP_AUIPC:             w_next = S_AUIPC;
                    default:                w_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                sel_a   = 2'd1;
                alu_sel = {w_funct3, instr[30]};
                w_next  = S_ALU_WB;
            end
            S_EXEC_I: begin
                sel_a   = 2'd1;
                sel_b   = 2'd1;
                alu_sel = {w_funct3, (w_funct3 == 3'b101) & instr[30]};
                w_next  = S_ALU_WB;
            end
            S_LUI: begin
                sel_a  = 2'd3;
                sel_b  = 2'd1;
                w_next = S_ALU_WB;
            end
            S_AUIPC: begin
                sel_a  = 2'd2;
                sel_b  = 2'd1;
                w_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_we = 1'b1;
                w_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                sel_a  = 2'd1;
                sel_b  = 2'd1;
                w_next = w_opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                addr_sel  = 1'b1;
                mem_valid = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                res_sel = 2'd1;
                reg_we  = 1'b1;
                w_next  = S_FETCH;
            end
            S_MEM_WR: begin
                addr_sel  = 1'b1;
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_BRANCH: begin
                sel_a  = 2'd1;
                pc_src = 1'b1;
                case (w_funct3[2:1])
                    2'b00:   alu_sel = c_ALU_SUB;
                    2'b10:   alu_sel = c_ALU_SLT;
                    2'b11:   alu_sel = c_ALU_SLTU;
                    default: alu_sel = c_ALU_ADD;
                endcase
                if (w_funct3[2:1] == 2'b01) begin
                    w_next = S_ILLEGAL;
                end else begin
                    pc_we  = w_taken;
                    w_next = S_FETCH;
                end
            end
            S_JALR_ADDR: begin
                sel_a  = 2'd1;
                sel_b  = 2'd1;
                w_next = S_LINK;
            end
            S_LINK: begin
                sel_a   = 2'd2;
                sel_b   = 2'd2;
                res_sel = 2'd2;
                reg_we  = 1'b1;
                pc_src  = 1'b1;
                pc_we   = 1'b1;
                w_next  = S_FETCH;
            end
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:   w_next = S_FETCH;
        endcase
        // Reset forces every strobe and select quiet regardless of state
        if (!nreset) begin
            alu_sel   = 4'd0;
            sel_a     = 2'd0;
            sel_b     = 2'd0;
            imm_sel   = 3'd0;
            res_sel   = 2'd0;
            pc_src    = 1'b0;
            addr_sel  = 1'b0;
            mem_valid = 1'b0;
            mem_we    = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            reg_we    = 1'b0;
        end
    end

    assign illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo: directed self-checking bench for the multi-cycle control FSM
// Rev 1.0 - initial release
`default_nettype none

module tb_control_multiciclo;

    logic        clk;
    logic        nreset;
    logic [31:0] instr;
    logic        alu_z;
    logic        mem_ready;
    logic [3:0]  alu_sel;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [2:0]  imm_sel;
    logic [1:0]  res_sel;
    logic        pc_src;
    logic        addr_sel;
    logic        mem_valid;
    logic        mem_we;
    logic        ir_we;
    logic        pc_we;
    logic        reg_we;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_pcwe  = 0;
    int n_irwe  = 0;
    int n_regwe = 0;

    control_multiciclo dut (
        .clk       (clk),
        .nreset    (nreset),
        .instr     (instr),
        .alu_z     (alu_z),
        .mem_ready (mem_ready),
        .alu_sel   (alu_sel),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .imm_sel   (imm_sel),
        .res_sel   (res_sel),
        .pc_src    (pc_src),
        .addr_sel  (addr_sel),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .reg_we    (reg_we),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters sampled at the edge that acts on them
    always @(posedge clk) begin
        if (pc_we)  n_pcwe++;
        if (ir_we)  n_irwe++;
        if (reg_we) n_regwe++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  alu;
        logic [1:0]  b;
    } alu_vec_t;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        logic [3:0]  alu;
        logic        we;
    } br_vec_t;

    alu_vec_t alu_tab[3];
    br_vec_t  br_tab[3];

    initial begin
        int p0, i0, r0, c0;
        logic [4:0] strobes;

        alu_tab[0] = '{32'h4020D1B3, 4'b1011, 2'd0};
        alu_tab[1] = '{32'h4000D193, 4'b1011, 2'd1};
        alu_tab[2] = '{32'h4010C193, 4'b1000, 2'd1};
        br_tab[0]  = '{32'h00208463, 1'b1, 4'b0001, 1'b1};
        br_tab[1]  = '{32'h00208463, 1'b0, 4'b0001, 1'b0};
        br_tab[2]  = '{32'h0020E463, 1'b0, 4'b0110, 1'b1};

        nreset    = 1'b0;
        instr     = 32'h0;
        alu_z     = 1'b0;
        mem_ready = 1'b0;
        #12;
        check("rst_mem_valid", mem_valid, 0);
        check("rst_sel_b", sel_b, 0);
        check("rst_illegal", illegal, 0);
        mem_ready = 1'b1;
        instr     = 32'h002081B3;
        #1;
        check("rst_ir_we", ir_we, 0);
        check("rst_pc_we", pc_we, 0);

        // add x3,x1,x2
        @(negedge clk);
        nreset = 1'b1;
        #1;
        check("add_fetch_valid", mem_valid, 1);
        check("add_fetch_selb", sel_b, 2);
        check("add_fetch_irwe", ir_we, 1);
        p0 = n_pcwe; i0 = n_irwe; c0 = cyc;
        tick();
        check("add_dec_sela", sel_a, 2);
        check("add_dec_selb", sel_b, 1);
        check("add_dec_irwe", ir_we, 0);
        tick();
        check("add_ex_alu", alu_sel, 4'b0000);
        check("add_ex_sela", sel_a, 1);
        check("add_ex_selb", sel_b, 0);
        tick();
        check("add_wb_regwe", reg_we, 1);
        check("add_wb_ressel", res_sel, 0);
        tick();
        check("add_pcwe_count", n_pcwe - p0, 1);
        check("add_irwe_count", n_irwe - i0, 1);
        check("add_cycles", cyc - c0, 4);
        check("add_back_fetch", mem_valid & ~addr_sel, 1);

        // ALU code decode for sra / srai / xori
        for (int k = 0; k < 3; k++) begin
            instr = alu_tab[k].ins;
            tick();
            tick();
            check($sformatf("alu%0d_sel", k), alu_sel, alu_tab[k].alu);
            check($sformatf("alu%0d_selb", k), sel_b, alu_tab[k].b);
            tick();
            tick();
        end

        // load with 3 wait cycles in MEM_RD
        instr = 32'h0040A183;
        r0 = n_regwe; c0 = cyc;
        tick();
        tick();
        check("ld_addr_sela", sel_a, 1);
        check("ld_addr_imm", imm_sel, 0);
        mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ld_wait%0d", k), {mem_valid, addr_sel, reg_we}, 3'b110);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("ld_ready_valid", mem_valid, 1);
        tick();
        check("ld_wb_ressel", res_sel, 1);
        check("ld_wb_regwe", reg_we, 1);
        tick();
        check("ld_cycles", cyc - c0, 8);
        check("ld_regwe_count", n_regwe - r0, 1);

        // branches
        for (int k = 0; k < 3; k++) begin
            instr = br_tab[k].ins;
            alu_z = br_tab[k].z;
            tick();
            tick();
            check($sformatf("br%0d_alu", k), alu_sel, br_tab[k].alu);
            check($sformatf("br%0d_pcwe", k), pc_we, br_tab[k].we);
            check($sformatf("br%0d_pcsrc", k), pc_src, 1);
            check($sformatf("br%0d_imm", k), imm_sel, 2);
            tick();
            check($sformatf("br%0d_fetch", k), mem_valid & ~addr_sel, 1);
        end
        alu_z = 1'b0;

        // jal
        instr = 32'h008000EF;
        tick();
        check("jal_dec_imm", imm_sel, 4);
        check("jal_dec_alu", {alu_sel, sel_a, sel_b}, {4'b0000, 2'd2, 2'd1});
        tick();
        check("jal_link_ressel", res_sel, 2);
        check("jal_link_strobes", {reg_we, pc_we, pc_src}, 3'b111);
        check("jal_link_selb", sel_b, 2);
        tick();

        // store
        instr = 32'h0020A223;
        r0 = n_regwe;
        tick();
        tick();
        tick();
        check("st_memwe", {mem_valid, mem_we, addr_sel}, 3'b111);
        check("st_imm", imm_sel, 1);
        tick();
        check("st_no_regwe", n_regwe - r0, 0);

        // illegal opcode
        instr = 32'h0000000B;
        tick();
        tick();
        check("ill_flag", illegal, 1);
        strobes = 5'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            strobes |= {mem_valid, mem_we, ir_we, pc_we, reg_we};
        end
        check("ill_strobes", strobes, 0);
        check("ill_sticky", illegal, 1);

        // asynchronous reset between clock edges clears illegal
        #2 nreset = 1'b0;
        #1;
        check("arst_ill_clear", illegal, 0);
        #1 nreset = 1'b1;
        #1;
        check("arst_fetch", {mem_valid, addr_sel, illegal}, 3'b100);

        // reset mid-MEM_RD aborts the load
        instr = 32'h0040A183;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("abort_in_memrd", addr_sel, 1);
        r0 = n_regwe;
        #2 nreset = 1'b0;
        #1;
        check("abort_quiet", {mem_valid, reg_we}, 2'b00);
        #1 nreset = 1'b1;
        #1;
        check("abort_fetch", {mem_valid, addr_sel}, 2'b10);
        mem_ready = 1'b1;
        instr = 32'h002081B3;
        tick();
        tick();
        check("abort_no_regwe", n_regwe - r0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
